// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline write-back and a long-latency source
module wb_port_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  output logic        stall_req_o,
  output logic        w_enable_o,
  output logic [4:0]  w_addr_o,
  output logic [31:0] w_data_o
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_hold_addr;
  logic [31:0] r_hold_data;
  logic [3:0]  r_wait_cnt, w_wait_nxt, w_wait_inc;
  logic        w_pipe_req, w_force, w_capture;
  assign w_pipe_req  = pipe_we_i & (pipe_waddr_i != 5'd0);
  assign w_force     = lu_valid_i & (r_wait_cnt >= 4'(MAX_WAIT));
  assign w_wait_inc  = (r_wait_cnt >= 4'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + 4'd1;
  assign stall_req_o = (r_state == HOLD);
  // Outputs are suppressed while rst is high so a parked write never lands during reset.
  always_comb begin
    w_next     = IDLE;
    w_wait_nxt = r_wait_cnt;
    w_capture  = 1'b0;
    lu_ready_o = 1'b0;
    w_enable_o = 1'b0;
    w_addr_o   = 5'd0;
    w_data_o   = 32'd0;
    if (rst) begin
      w_wait_nxt = 4'd0;
    end else if (r_state == HOLD) begin
      w_enable_o = 1'b1;
      w_addr_o   = r_hold_addr;
      w_data_o   = r_hold_data;
      w_wait_nxt = lu_valid_i ? w_wait_inc : r_wait_cnt;
    end else if (w_pipe_req && !w_force) begin
      w_enable_o = 1'b1;
      w_addr_o   = pipe_waddr_i;
      w_data_o   = pipe_wdata_i;
      w_wait_nxt = lu_valid_i ? w_wait_inc : r_wait_cnt;
    end else if (lu_valid_i) begin
      lu_ready_o = 1'b1;
      w_enable_o = (lu_waddr_i != 5'd0);
      w_addr_o   = w_enable_o ? lu_waddr_i : 5'd0;
      w_data_o   = w_enable_o ? lu_wdata_i : 32'd0;
      w_wait_nxt = 4'd0;
      w_capture  = w_pipe_req;
      w_next     = w_pipe_req ? HOLD : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold_addr <= 5'd0;
      r_hold_data <= 32'd0;
      r_wait_cnt  <= 4'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      if (w_capture) begin
        r_hold_addr <= pipe_waddr_i;
        r_hold_data <= pipe_wdata_i;
      end
    end
  end
endmodule
